qspi_psram_writer: RTL and testbench
====================================

# qspi_psram_writer

Quad-SPI write initiator that streams bytes from a valid/ready source into the external QSPI PSRAM (RAM A select line) using the single-bit-command, quad-address/data write command. It mirrors the flash read path: the read engine pulls pixel bytes out of external memory, and this block pushes frame data in. Bursts are split automatically at PSRAM page boundaries. It shares the uio pad mux with the read engine, and top-level arbitration selects which engine drives the pads.

## Interface
- `CMD`, 8'h38: write command byte, sent MSB first on D0.
- `PAGE_BITS`, 10: log2 of the PSRAM page size in bytes; a burst never crosses a page.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `addr_in`  in  24  start byte address, sampled when `start_write` is accepted.
- `start_write`  in  1  pulse that begins a write burst; ignored while `busy`.
- `stop_write`  in  1  ends the burst at the next byte boundary; level-sampled.
- `data_in`  in  8  write byte.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block accepts `data_in` this cycle.
- `busy`  out  1  a transaction is in progress.
- `qspi_data_out`  out  4  D3..D0 drive values.
- `qspi_data_oe`  out  4  per-line output enable, active high.
- `qspi_select`  out  1  PSRAM chip select, active low.
- `qspi_clk_out`  out  1  SCK.

## Operation
- All outputs are registered.
- SCK runs at clk/2. Each SPI bit or nibble takes 2 cycles: phase 0 drives new data with SCK=0, phase 1 holds data with SCK=1. The PSRAM samples on the rising edge of SCK.
- The state machine has these states: IDLE, CMD, ADDR, DATA, DESEL.
- **IDLE**
  - Outputs: select=1, SCK=0, oe=0000, data_out=0000.
  - On `start_write`: latch `addr_in` into the address counter, clear `stop_pending`, go to CMD.
- **CMD**
  - 16 cycles; D0 carries `CMD[7]` down to `CMD[0]`.
  - oe=0001; D3..D1 drive 0.
- **ADDR**
  - 12 cycles: 6 nibbles of the 24-bit address, MSB nibble first.
  - oe=1111.
- **DATA**
  - oe=1111.
  - A byte boundary is either the first DATA cycle or phase 1 of the last nibble of the current byte.
  - `data_ready` = (state==DATA) && at byte boundary && !`stop_pending` && !`stop_write`.
  - On accept (`data_valid && data_ready`), the byte is shifted out over the next 4 cycles: high nibble, then low nibble. The address counter increments by 1.
  - At a byte boundary with no accept and no stop, the block stalls: SCK held 0, data lines hold the last value, select stays low.
  - At a byte boundary with a stop (`stop_write` or `stop_pending`), go to DESEL.
  - After the last byte of a page completes (counter low `PAGE_BITS` bits wrap to 0), go to DESEL with `rollover` set.
- **DESEL**
  - 2 cycles: select=1, SCK=0, oe=0000.
  - Then go to CMD (new address) if `rollover`, else to IDLE.
- `stop_write` seen while in CMD or ADDR sets `stop_pending`. The stop is applied at the first DATA boundary, giving a zero-byte burst.
- At a boundary, `stop_write` wins over `data_valid`; the byte is not accepted.
- The address counter is 24 bits and wraps from 0xFFFFFF to 0x000000.
- The PSRAM limits maximum CS-low time (tCEM). Keeping stalls short enough to respect it is the source's responsibility.

## Timing
- Reset values: select=1, SCK=0, data_out=0000, oe=0000, `busy`=0, `data_ready`=0. All state returns to IDLE.
- Reset applies on the next edge from any state, including mid-burst.
- Cycle numbering, with `start_write` at cycle 0:
  - Cycle 1: select low, `busy` high, D0=`CMD[7]`.
  - Cycles 1–16: CMD.
  - Cycles 17–28: ADDR.
  - Cycle 29: first DATA cycle, `data_ready`=1.
- Byte accepted at cycle N:
  - N+1: high nibble, SCK 0.
  - N+2: SCK 1.
  - N+3: low nibble, SCK 0.
  - N+4: SCK 1, and `data_ready` high again.
- Sustained throughput is 1 byte per 4 cycles.
- Stop at boundary cycle B: B+1 and B+2 are DESEL, B+3 is IDLE with `busy`=0.
- Rollover: last page byte finishes at cycle M. M+1 and M+2 are DESEL; M+3 is CMD restart at the next page address.

## Test plan
- Basic burst:
  - Stimulus: `addr_in`=0x000100; feed bytes 0xA5, 0x3C back-to-back; then assert `stop_write`.
  - Required response: D0 serial 0x38 over 8 rising edges; address nibbles 0,0,0,1,0,0; data nibbles A,5,3,C; select rises 1 cycle after the boundary; `busy` drops 3 cycles after the boundary.
- Stall:
  - Stimulus: drop `data_valid` for 5 cycles between bytes.
  - Required response: no SCK edges during the stall, select stays low, next byte's nibbles are correct.
- Page rollover:
  - Stimulus: start at 0x0003FE, send 4 bytes.
  - Required response: first burst carries 2 bytes; 2-cycle deselect; new CMD with address 0x000400 carrying 2 bytes.
- Stop during CMD:
  - Stimulus: pulse `stop_write` during CMD.
  - Required response: full CMD and ADDR phases, `data_ready` never asserted, DESEL, then IDLE.
- Simultaneous events:
  - Stimulus: `stop_write` and `data_valid` at the same boundary; separately, `start_write` while `busy`.
  - Required response: byte rejected; second start ignored and the latched address is unchanged.
- Reset mid-ADDR:
  - Stimulus: assert `rst` during ADDR.
  - Required response: next cycle select=1, SCK=0, oe=0000, `busy`=0; a subsequent start behaves normally.

Source files
------------

// File: rtl/qspi_psram_writer.sv
// QSPI PSRAM write initiator: 1-bit command, quad address/data, bursts split at page ends.
// First data_ready 29 cycles after start, then 1 byte per 4 cycles; a missing byte stalls with SCK low.
module qspi_psram_writer #(
  parameter logic [7:0] CMD       = 8'h38,
  parameter int         PAGE_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] addr_in,
  input  logic        start_write,
  input  logic        stop_write,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        busy,
  output logic [3:0]  qspi_data_out,
  output logic [3:0]  qspi_data_oe,
  output logic        qspi_select,
  output logic        qspi_clk_out
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DESEL} state_t;

  state_t      r_state, w_state;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_idle, w_idle;
  logic [23:0] r_addr, w_addr;
  logic [7:0]  r_byte, w_byte;
  logic        r_stop_pend, w_stop_pend;
  logic        r_rollover, w_rollover;
  logic [3:0]  r_dout, w_dout;
  logic [3:0]  r_oe, w_oe;
  logic        r_sel, w_sel;
  logic        r_sck, w_sck;
  logic        r_busy, w_busy;
  logic        r_rdy, w_rdy;
  logic        w_at_bnd, w_page_end, w_accept;

  // r_idle marks a DATA boundary that is not phase 1 of a nibble: first DATA cycle or a stall
  assign w_at_bnd   = (r_state == S_DATA) && (r_idle || r_cnt == 4'd3);
  assign w_page_end = !r_idle && (r_addr[PAGE_BITS-1:0] == '0);
  // stop_write gates ready directly so a stop at a boundary can never complete a handshake
  assign data_ready = r_rdy && !stop_write;
  assign w_accept   = data_ready && data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idle      <= 1'b0;
      r_addr      <= '0;
      r_byte      <= '0;
      r_stop_pend <= 1'b0;
      r_rollover  <= 1'b0;
      r_dout      <= '0;
      r_oe        <= '0;
      r_sel       <= 1'b1;
      r_sck       <= 1'b0;
      r_busy      <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idle      <= w_idle;
      r_addr      <= w_addr;
      r_byte      <= w_byte;
      r_stop_pend <= w_stop_pend;
      r_rollover  <= w_rollover;
      r_dout      <= w_dout;
      r_oe        <= w_oe;
      r_sel       <= w_sel;
      r_sck       <= w_sck;
      r_busy      <= w_busy;
      r_rdy       <= w_rdy;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idle      = r_idle;
    w_addr      = r_addr;
    w_byte      = r_byte;
    w_stop_pend = r_stop_pend;
    w_rollover  = r_rollover;
    case (r_state)
      S_IDLE: begin
        if (start_write) begin
          w_state     = S_CMD;
          w_cnt       = '0;
          w_addr      = addr_in;
          w_stop_pend = 1'b0;
          w_rollover  = 1'b0;
        end
      end
      S_CMD: begin
        if (stop_write) w_stop_pend = 1'b1;
        w_cnt = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_state = S_ADDR;
          w_cnt   = '0;
        end
      end
      S_ADDR: begin
        if (stop_write) w_stop_pend = 1'b1;
        w_cnt = r_cnt + 4'd1;
        if (r_cnt == 4'd11) begin
          w_state = S_DATA;
          w_cnt   = '0;
          w_idle  = 1'b1;
        end
      end
      S_DATA: begin
        if (!w_at_bnd) begin
          w_cnt = r_cnt + 4'd1;
        end else if (stop_write || r_stop_pend) begin
          w_state    = S_DESEL;
          w_cnt      = '0;
          w_rollover = 1'b0;
        end else if (w_page_end) begin
          w_state    = S_DESEL;
          w_cnt      = '0;
          w_rollover = 1'b1;
        end else if (w_accept) begin
          w_cnt  = '0;
          w_idle = 1'b0;
          w_byte = data_in;
          w_addr = r_addr + 24'd1;
        end else begin
          w_idle = 1'b1;
        end
      end
      S_DESEL: begin
        w_cnt = r_cnt + 4'd1;
        if (r_cnt == 4'd1) begin
          w_cnt      = '0;
          w_state    = r_rollover ? S_CMD : S_IDLE;
          w_rollover = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Pad values are decoded from the next state so every output leaves a flop
  always_comb begin
    w_sel  = 1'b1;
    w_sck  = 1'b0;
    w_oe   = 4'b0000;
    w_dout = 4'b0000;
    w_busy = 1'b1;
    w_rdy  = 1'b0;
    case (w_state)
      S_IDLE: w_busy = 1'b0;
      S_CMD: begin
        w_sel  = 1'b0;
        w_sck  = w_cnt[0];
        w_oe   = 4'b0001;
        w_dout = {3'b000, CMD[3'd7 - w_cnt[3:1]]};
      end
      S_ADDR: begin
        w_sel  = 1'b0;
        w_sck  = w_cnt[0];
        w_oe   = 4'b1111;
        w_dout = w_addr[5'd20 - {w_cnt[3:1], 2'b00} +: 4];
      end
      S_DATA: begin
        w_sel = 1'b0;
        w_oe  = 4'b1111;
        if (w_idle) begin
          w_dout = r_dout;
        end else begin
          w_sck  = w_cnt[0];
          w_dout = w_cnt[1] ? w_byte[3:0] : w_byte[7:4];
        end
        w_rdy = (w_idle || w_cnt == 4'd3) && !w_stop_pend &&
                (w_idle || w_addr[PAGE_BITS-1:0] != '0);
      end
      S_DESEL: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  assign busy          = r_busy;
  assign qspi_data_out = r_dout;
  assign qspi_data_oe  = r_oe;
  assign qspi_select   = r_sel;
  assign qspi_clk_out  = r_sck;

endmodule

// File: tb/tb_qspi_psram_writer.sv
// Scoreboard bench: stimulus queues expected bursts, a pad monitor decodes and checks each one.
module tb_qspi_psram_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] addr_in;
  logic        start_write, stop_write;
  logic [7:0]  data_in;
  logic        data_valid, data_ready, busy;
  logic [3:0]  qspi_data_out, qspi_data_oe;
  logic        qspi_select, qspi_clk_out;

  always #5 clk = ~clk;

  qspi_psram_writer dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .start_write(start_write),
    .stop_write(stop_write), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .qspi_data_out(qspi_data_out),
    .qspi_data_oe(qspi_data_oe), .qspi_select(qspi_select), .qspi_clk_out(qspi_clk_out)
  );

  int total = 0, bad = 0, txn_seen = 0;
  int w, stall_sck, stall_sel, rdy_seen;
  logic [23:0] exp_addr[$];
  int          exp_len[$];
  logic [7:0]  exp_bytes[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_burst(input logic [23:0] a);
    addr_in = a;
    start_write = 1'b1;
    tick(1);
    start_write = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    data_in = b;
    data_valid = 1'b1;
    waited = 0;
    while (!data_ready && waited < 100) begin
      tick(1);
      waited++;
    end
    if (!data_ready) begin
      total++;
      bad++;
      $display("FAIL send timeout: got data_ready=0 want 1 within 100 cycles");
    end
    tick(1);
    data_valid = 1'b0;
  endtask

  // Called the cycle after an accept; the byte's last phase is the boundary B
  task automatic finish_stop();
    stop_write = 1'b1;
    tick(3);
    data_in = 8'hEE;
    data_valid = 1'b1;
    chk("ready at stop boundary", data_ready, 1'b0);
    tick(1);
    data_valid = 1'b0;
    chk("select B+1", qspi_select, 1'b1);
    tick(1);
    chk("busy B+2", busy, 1'b1);
    tick(1);
    chk("busy B+3", busy, 1'b0);
    stop_write = 1'b0;
  endtask

  // Pad monitor: samples while SCK is high, mid-cycle
  logic        m_in = 1'b0;
  int          m_cmdn, m_addrn, m_nib, m_bytes;
  logic [7:0]  m_cmd;
  logic [23:0] m_addr;
  logic [3:0]  m_hi;

  always @(negedge clk) begin
    if (rst) begin
      m_in = 1'b0;
    end else if (!qspi_select) begin
      if (!m_in) begin
        m_in = 1'b1; m_cmdn = 0; m_addrn = 0; m_nib = 0; m_bytes = 0;
      end
      if (qspi_clk_out) begin
        if (m_cmdn < 8) begin
          m_cmd = {m_cmd[6:0], qspi_data_out[0]};
          m_cmdn++;
        end else if (m_addrn < 6) begin
          m_addr = {m_addr[19:0], qspi_data_out};
          m_addrn++;
        end else if (m_nib == 0) begin
          m_hi = qspi_data_out;
          m_nib = 1;
        end else begin
          m_nib = 0;
          m_bytes++;
          if (exp_bytes.size() == 0) begin
            total++; bad++;
            $display("FAIL data byte: got 0x%0h want none", {m_hi, qspi_data_out});
          end else begin
            chk("data byte", {m_hi, qspi_data_out}, exp_bytes.pop_front());
          end
        end
      end
    end else if (m_in) begin
      m_in = 1'b0;
      txn_seen++;
      chk("cmd byte", m_cmd, 8'h38);
      chk("addr nibbles", m_addrn, 6);
      if (exp_addr.size() == 0) begin
        total++; bad++;
        $display("FAIL burst: got addr 0x%0h want no burst", m_addr);
      end else begin
        chk("burst addr", m_addr, exp_addr.pop_front());
        chk("burst len", m_bytes, exp_len.pop_front());
      end
    end
  end

  initial begin
    #200000;
    total++; bad++;
    $display("FAIL watchdog: got no end want end within time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1; addr_in = '0; start_write = 1'b0; stop_write = 1'b0;
    data_in = '0; data_valid = 1'b0;
    tick(3);
    chk("rst select", qspi_select, 1'b1);
    chk("rst sck", qspi_clk_out, 1'b0);
    chk("rst dout", qspi_data_out, 4'h0);
    chk("rst oe", qspi_data_oe, 4'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst ready", data_ready, 1'b0);
    rst = 1'b0;
    tick(2);

    // Basic burst
    exp_addr.push_back(24'h000100); exp_len.push_back(2);
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C);
    start_burst(24'h000100);
    chk("cyc1 select", qspi_select, 1'b0);
    chk("cyc1 busy", busy, 1'b1);
    chk("cyc1 d0", qspi_data_out, 4'h0);
    chk("cyc1 oe", qspi_data_oe, 4'b0001);
    tick(28);
    chk("cyc29 ready", data_ready, 1'b1);
    send_byte(8'hA5, w); chk("first accept wait", w, 0);
    send_byte(8'h3C, w); chk("b2b wait", w, 3);
    finish_stop();

    // Stall between bytes
    exp_addr.push_back(24'h000200); exp_len.push_back(2);
    exp_bytes.push_back(8'h11); exp_bytes.push_back(8'hC7);
    start_burst(24'h000200);
    tick(28);
    send_byte(8'h11, w);
    tick(3);
    stall_sck = 0; stall_sel = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (qspi_clk_out) stall_sck++;
      if (qspi_select) stall_sel++;
    end
    chk("stall sck edges", stall_sck, 0);
    chk("stall select high", stall_sel, 0);
    send_byte(8'hC7, w); chk("post-stall wait", w, 0);
    finish_stop();

    // Page rollover
    exp_addr.push_back(24'h0003FE); exp_len.push_back(2);
    exp_addr.push_back(24'h000400); exp_len.push_back(2);
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h03); exp_bytes.push_back(8'h04);
    start_burst(24'h0003FE);
    tick(28);
    send_byte(8'h01, w);
    send_byte(8'h02, w);
    data_in = 8'h03; data_valid = 1'b1;
    tick(3);
    chk("page end ready", data_ready, 1'b0);
    chk("page end select", qspi_select, 1'b0);
    tick(1); chk("rollover M+1 select", qspi_select, 1'b1);
    tick(1); chk("rollover M+2 select", qspi_select, 1'b1);
    tick(1); chk("rollover M+3 select", qspi_select, 1'b0);
    chk("rollover M+3 oe", qspi_data_oe, 4'b0001);
    send_byte(8'h03, w); chk("rollover restart wait", w, 28);
    send_byte(8'h04, w);
    finish_stop();

    // Stop during CMD: zero-byte burst
    exp_addr.push_back(24'h123456); exp_len.push_back(0);
    start_burst(24'h123456);
    data_in = 8'h77; data_valid = 1'b1; rdy_seen = 0;
    for (int c = 1; c < 32; c++) begin
      stop_write = (c == 3);
      if (data_ready) rdy_seen++;
      if (c == 29) chk("cmd stop select c29", qspi_select, 1'b0);
      if (c == 30) chk("cmd stop select c30", qspi_select, 1'b1);
      if (c == 31) chk("cmd stop busy c31", busy, 1'b1);
      tick(1);
    end
    stop_write = 1'b0; data_valid = 1'b0;
    chk("cmd stop ready never", rdy_seen, 0);
    chk("cmd stop busy c32", busy, 1'b0);

    // Start while busy is ignored; stop beats valid at the boundary
    exp_addr.push_back(24'h000500); exp_len.push_back(1);
    exp_bytes.push_back(8'h5A);
    start_burst(24'h000500);
    tick(4);
    addr_in = 24'h0ABCDE; start_write = 1'b1;
    tick(1);
    start_write = 1'b0;
    tick(23);
    send_byte(8'h5A, w); chk("busy-start accept wait", w, 0);
    finish_stop();
    tick(4);
    chk("no burst from ignored start", busy, 1'b0);

    // Reset mid-ADDR, then a normal burst
    start_burst(24'h00ABCD);
    tick(19);
    rst = 1'b1;
    tick(1);
    chk("mid rst select", qspi_select, 1'b1);
    chk("mid rst sck", qspi_clk_out, 1'b0);
    chk("mid rst oe", qspi_data_oe, 4'h0);
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst ready", data_ready, 1'b0);
    rst = 1'b0;
    tick(2);
    exp_addr.push_back(24'h000700); exp_len.push_back(1);
    exp_bytes.push_back(8'h99);
    start_burst(24'h000700);
    tick(28);
    send_byte(8'h99, w); chk("post-rst accept wait", w, 0);
    finish_stop();

    tick(5);
    chk("bursts seen", txn_seen, 7);
    chk("pending bursts", exp_addr.size(), 0);
    chk("pending bytes", exp_bytes.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
